// File: rtl/seg_scan_decoder_pkg.sv
// Shared 7-segment glyph encodings (active-low {g,f,e,d,c,b,a}) and scan-decoder FSM states.
// Used by both the display encoder and the loopback decoder so both ends agree on glyphs.
package seg_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HELD   = 1'b1;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } glyph_t;

  // {single digit enabled, digit index}; anything other than exactly one low bit is not a digit.
  function automatic logic [2:0] an_select(input logic [3:0] an);
    case (an)
      4'hE:    an_select = 3'b100;
      4'hD:    an_select = 3'b101;
      4'hB:    an_select = 3'b110;
      4'h7:    an_select = 3'b111;
      default: an_select = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational segment pattern -> {legal, blank, nibble}; blank and illegal patterns give nibble 0.
module seg_glyph_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output glyph_t     glyph
);

  always_comb begin
    glyph = '{legal: 1'b1, blank: 1'b0, nibble: 4'h0};
    case (seg)
      SEG_0:     glyph.nibble = 4'h0;
      SEG_1:     glyph.nibble = 4'h1;
      SEG_2:     glyph.nibble = 4'h2;
      SEG_3:     glyph.nibble = 4'h3;
      SEG_4:     glyph.nibble = 4'h4;
      SEG_5:     glyph.nibble = 4'h5;
      SEG_6:     glyph.nibble = 4'h6;
      SEG_7:     glyph.nibble = 4'h7;
      SEG_8:     glyph.nibble = 4'h8;
      SEG_9:     glyph.nibble = 4'h9;
      SEG_A:     glyph.nibble = 4'hA;
      SEG_B:     glyph.nibble = 4'hB;
      SEG_C:     glyph.nibble = 4'hC;
      SEG_D:     glyph.nibble = 4'hD;
      SEG_E:     glyph.nibble = 4'hE;
      SEG_F:     glyph.nibble = 4'hF;
      SEG_BLANK: glyph.blank  = 1'b1;
      default:   glyph.legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Loopback monitor for the scanned an/seg display lines: settles, decodes and assembles 4-digit frames.
// frame_valid pulses 1 + SETTLE_CYCLES + 1 cycles after the last digit's lines stabilise; no backpressure.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        bad_pattern,
  output logic        stale
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic [0:0]    state;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] timeout_cnt;
  logic [3:0]    seen;
  logic [15:0]   digit_buf;
  logic [3:0]    blank_buf;
  glyph_t        glyph;
  logic          changed, attempt, one_digit, capture, timeout_hit;
  logic [1:0]    idx;

  seg_glyph_decode u_glyph_decode (
    .seg   (seg_q),
    .glyph (glyph)
  );

  // A change is seen as the new sample is registered, so the held copy never lags the decision.
  assign changed          = {an, seg} != {an_q, seg_q};
  assign attempt          = (state == ST_SETTLE) && !changed && (settle_cnt == SETTLE_LAST);
  assign {one_digit, idx} = an_select(an_q);
  assign capture          = attempt && one_digit && glyph.legal;
  assign timeout_hit      = !capture && (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= 4'hF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an;
      seg_q <= seg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
    end else if (changed) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
    end else if (state == ST_SETTLE) begin
      if (settle_cnt == SETTLE_LAST) state <= ST_HELD;
      else settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_cnt <= '0;
      stale       <= 1'b0;
    end else if (capture) begin
      timeout_cnt <= '0;
      stale       <= 1'b0;
    end else if (timeout_cnt == TIMEOUT_LAST) begin
      stale <= 1'b1;
    end else begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen        <= 4'h0;
      digit_buf   <= 16'h0;
      blank_buf   <= 4'hF;
      digits      <= 16'h0;
      blank       <= 4'hF;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      frame_valid <= (seen == 4'hF);
      if (seen == 4'hF) begin
        digits <= digit_buf;
        blank  <= blank_buf;
        seen   <= 4'h0;
      end else if (capture) begin
        seen[idx] <= 1'b1;
      end else if (timeout_hit) begin
        seen <= 4'h0;
      end
      if (capture) begin
        digit_buf[{idx, 2'b00} +: 4] <= glyph.nibble;
        blank_buf[idx]               <= glyph.blank;
      end
      if (attempt && one_digit && !glyph.legal) bad_pattern <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed bench for seg_scan_decoder against a run-length based reference model.
module tb_seg_scan_decoder;

  localparam int S = 4;
  localparam int T = 4096;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an    = 4'hF;
  logic [6:0]  seg   = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_valid, bad_pattern, stale;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: the lines are a sequence of constant runs; a run captures iff it lasts > S cycles.
  logic [3:0]  m_seen, m_blank;
  logic [15:0] m_buf;
  logic        m_bad;
  logic [3:0]  cur_an;
  logic [6:0]  cur_seg;
  int          cur_len;
  logic [19:0] exp_q [$];
  logic [19:0] obs_q [$];
  int          obs_cyc [$];

  seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .blank       (blank),
    .frame_valid (frame_valid),
    .bad_pattern (bad_pattern),
    .stale       (stale)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset === 1'b0 && frame_valid === 1'b1) begin
      obs_q.push_back({digits, blank});
      obs_cyc.push_back(cyc);
    end
  end

  function automatic int glyph_value(input logic [6:0] s);
    if (s == 7'h7F) return 16;
    for (int k = 0; k < 16; k++) if (glyph_tab[k] == s) return k;
    return -1;
  endfunction

  function automatic int digit_index(input logic [3:0] a);
    int n = 0;
    int pos = -1;
    for (int k = 0; k < 4; k++) if (!a[k]) begin n++; pos = k; end
    return (n == 1) ? pos : -1;
  endfunction

  task automatic model_run_end();
    int d, v;
    if (cur_len >= S + 1) begin
      d = digit_index(cur_an);
      if (d >= 0) begin
        v = glyph_value(cur_seg);
        if (v < 0) m_bad = 1'b1;
        else begin
          m_seen[d]      = 1'b1;
          m_buf[4*d +: 4] = (v == 16) ? 4'h0 : 4'(v);
          m_blank[d]     = (v == 16);
          if (m_seen == 4'hF) begin
            exp_q.push_back({m_buf, m_blank});
            m_seen = 4'h0;
          end
        end
      end
    end
  endtask

  task automatic model_clear();
    m_seen = 4'h0; m_buf = 16'h0; m_blank = 4'hF; m_bad = 1'b0;
    cur_an = 4'hF; cur_seg = 7'h7F; cur_len = 0;
  endtask

  task automatic clear_queues();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  // Called just after a rising edge; holds the lines for n rising edges.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    if (a == cur_an && s == cur_seg) cur_len += n;
    else begin
      model_run_end();
      cur_an = a; cur_seg = s; cur_len = n;
    end
    an = a; seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input int n);
    drive(4'hE, s0, n); drive(4'hD, s1, n); drive(4'hB, s2, n); drive(4'h7, s3, n);
  endtask

  task automatic do_reset();
    reset = 1'b1; an = 4'hF; seg = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; an = 4'hF; seg = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({digits, blank, frame_valid, bad_pattern, stale} !== {16'h0, 4'hF, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_values: got digits=%h blank=%h fv=%b bad=%b stale=%b want 0000/f/0/0/0",
               digits, blank, frame_valid, bad_pattern, stale);
    end
    reset = 1'b0;
    model_clear();
    clear_queues();
    repeat (T - 1) @(posedge clk);
    #1;
    tests_run++;
    if (stale !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_early: got %b after %0d cycles, want 0", stale, T - 1);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (stale !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_rise: got %b after %0d cycles, want 1", stale, T);
    end
    tests_run++;
    if (obs_q.size() != 0 || digits !== 16'h0 || blank !== 4'hF) begin
      tests_failed++;
      $display("FAIL idle_no_frame: got %0d frames digits=%h blank=%h, want 0 frames 0000/f",
               obs_q.size(), digits, blank);
    end
  endtask

  task automatic test_scan();
    int t3;
    clear_queues();
    drive(4'hE, 7'h79, 20);
    tests_run++;
    if (stale !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_clear: got %b after a capture, want 0", stale);
    end
    drive(4'hD, 7'h24, 20);
    drive(4'hB, 7'h30, 20);
    t3 = cyc;
    drive(4'h7, 7'h19, 20);
    drive(4'hF, 7'h7F, 12);
    tests_run++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      tests_failed++;
      $display("FAIL scan_count: got %0d frames, want 1 (model %0d)", obs_q.size(), exp_q.size());
    end else begin
      tests_run++;
      if (obs_q[0] !== {16'h4321, 4'h0} || obs_q[0] !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL scan_frame: got %h want %h", obs_q[0], {16'h4321, 4'h0});
      end
      tests_run++;
      if (obs_cyc[0] != t3 + S + 2) begin
        tests_failed++;
        $display("FAIL scan_latency: got frame at cycle %0d want %0d", obs_cyc[0], t3 + S + 2);
      end
    end
    tests_run++;
    if (bad_pattern !== 1'b0) begin
      tests_failed++;
      $display("FAIL scan_bad: got %b want 0", bad_pattern);
    end
  endtask

  task automatic test_short_hold();
    clear_queues();
    scan4(7'h79, 7'h24, 7'h30, 7'h19, S - 1);
    scan4(7'h40, 7'h10, 7'h08, 7'h0E, S);
    drive(4'hF, 7'h7F, 12);
    tests_run++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL short_hold: got %0d frames want 0 (model %0d)", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_bad_pattern();
    clear_queues();
    scan4(7'h79, 7'h24, 7'h55, 7'h30, 20);
    drive(4'hF, 7'h7F, 12);
    tests_run++;
    if (bad_pattern !== 1'b1 || obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bad_detect: got bad=%b frames=%0d want bad=1 frames=0", bad_pattern, obs_q.size());
    end
    drive(4'hB, 7'h19, 20);
    drive(4'hF, 7'h7F, 12);
    tests_run++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      tests_failed++;
      $display("FAIL bad_recover_count: got %0d frames want 1", obs_q.size());
    end else if (obs_q[0] !== {16'h3421, 4'h0} || obs_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL bad_recover_frame: got %h want %h", obs_q[0], {16'h3421, 4'h0});
    end
    tests_run++;
    if (bad_pattern !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_sticky: got %b want 1", bad_pattern);
    end
    do_reset();
    tests_run++;
    if (bad_pattern !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_reset: got %b want 0", bad_pattern);
    end
  endtask

  task automatic test_multi_an_blank();
    clear_queues();
    drive(4'hD, 7'h24, 20); drive(4'hB, 7'h30, 20); drive(4'h7, 7'h19, 20);
    drive(4'hC, 7'h40, 50);
    tests_run++;
    if (obs_q.size() != 0 || bad_pattern !== 1'b0) begin
      tests_failed++;
      $display("FAIL two_digits_on: got frames=%0d bad=%b want 0/0", obs_q.size(), bad_pattern);
    end
    drive(4'hE, 7'h12, 20);
    drive(4'hF, 7'h7F, 12);
    scan4(7'h79, 7'h24, 7'h30, 7'h7F, 20);
    drive(4'hF, 7'h7F, 12);
    tests_run++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      tests_failed++;
      $display("FAIL blank_count: got %0d frames want 2", obs_q.size());
    end else begin
      tests_run++;
      if (obs_q[0] !== {16'h4325, 4'h0} || obs_q[0] !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL seen_kept: got %h want %h", obs_q[0], {16'h4325, 4'h0});
      end
      tests_run++;
      if (obs_q[1] !== {16'h0321, 4'h8} || obs_q[1] !== exp_q[1]) begin
        tests_failed++;
        $display("FAIL blank_digit: got %h want %h", obs_q[1], {16'h0321, 4'h8});
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_queues();
    drive(4'hE, 7'h79, 20);
    drive(4'hD, 7'h24, 20);
    do_reset();
    scan4(7'h40, 7'h10, 7'h08, 7'h0E, 20);
    drive(4'hF, 7'h7F, 12);
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== {16'hFA90, 4'h0}) begin
      tests_failed++;
      $display("FAIL midframe_reset: got %0d frames first=%h want 1 frame %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 20'h0, {16'hFA90, 4'h0});
    end
    clear_queues();
    for (int v = 9; v >= 0; v--) scan4(glyph_tab[v], 7'h10, 7'h08, 7'h0E, 8);
    drive(4'hF, 7'h7F, 12);
    tests_run++;
    if (obs_q.size() != 10) begin
      tests_failed++;
      $display("FAIL countdown_count: got %0d frames want 10", obs_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        tests_run++;
        if (obs_q[k] !== {12'hFA9, 4'(9 - k), 4'h0} || obs_q[k] !== exp_q[k]) begin
          tests_failed++;
          $display("FAIL countdown_%0d: got %h want %h", k, obs_q[k], {12'hFA9, 4'(9 - k), 4'h0});
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    clear_queues();
    for (int r = 0; r < 150; r++) begin
      logic [3:0] a;
      logic [6:0] s;
      int p;
      p = $urandom_range(0, 15);
      a = (p == 0) ? 4'($urandom_range(0, 15)) : ~(4'b0001 << $urandom_range(0, 3));
      p = $urandom_range(0, 9);
      if (p == 0) s = 7'($urandom_range(0, 127));
      else if (p == 1) s = 7'h7F;
      else s = glyph_tab[$urandom_range(0, 15)];
      drive(a, s, $urandom_range(S - 1, S + 5));
    end
    drive(4'hF, 7'h7F, 12);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d frames want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < obs_q.size(); k++) begin
        tests_run++;
        if (obs_q[k] !== exp_q[k]) begin
          tests_failed++;
          $display("FAIL rand_frame_%0d: got %h want %h", k, obs_q[k], exp_q[k]);
        end
      end
    end
    tests_run++;
    if (bad_pattern !== m_bad || stale !== 1'b0) begin
      tests_failed++;
      $display("FAIL rand_flags: got bad=%b stale=%b want bad=%b stale=0", bad_pattern, stale, m_bad);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_scan();
    test_short_hold();
    test_bad_pattern();
    test_multi_an_blank();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
